// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction codes, screen geometry and the
// 800x525 raster timing totals so the renderer and motion logic agree.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    // Button bit order is [0]=up, [1]=left, [2]=right, [3]=down.
    // When several bits rise together, UP > LEFT > RIGHT > DOWN.
    function automatic dir_t prio_dir(input logic [3:0] r);
        dir_t d;
        if (r[0])      d = DIR_UP;
        else if (r[1]) d = DIR_LEFT;
        else if (r[2]) d = DIR_RIGHT;
        else           d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/turn_buffer.sv
// Button edge detect plus a one-entry turn request register.
// A held button yields a single request; the latest press overwrites any
// earlier one until the consumer clears it on a frame tick. The same-cycle
// rise is exported so a press landing on the tick itself is not lost.
module turn_buffer
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       clear,
    input  logic [3:0] btn,
    output logic       rise_any,
    output dir_t       rise_dir,
    output logic       pending_valid,
    output dir_t       pending_dir
);

    logic [3:0] btn_q;
    logic [3:0] rise;

    // Rising edges relative to the button levels seen on the previous ce cycle.
    always_comb begin
        rise     = btn & ~btn_q;
        rise_any = |rise;
        rise_dir = prio_dir(rise);
    end

    // Button history and pending request; nothing moves while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q         <= 4'b0000;
            pending_valid <= 1'b0;
            pending_dir   <= DIR_RIGHT;
        end else if (ce) begin
            btn_q <= btn;
            if (clear) begin
                pending_valid <= 1'b0;
            end else if (rise_any) begin
                pending_valid <= 1'b1;
                pending_dir   <= rise_dir;
            end
        end
    end

endmodule

// File: rtl/pac_motion.sv
// Pacman position, facing and animation pacing. All state advances only on
// an unpaused start-of-frame tick so the sprite never changes mid-scan.
module pac_motion
    import pacman_pkg::*;
#(
    parameter int SCALE    = 2,
    parameter int SPRITE_W = 16,
    parameter int SCREEN_W = pacman_pkg::SCREEN_W,
    parameter int SCREEN_H = pacman_pkg::SCREEN_H,
    parameter int ANIM_DIV = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               frame_tick,
    input  logic [3:0]         btn,
    input  logic               pause,
    output logic signed [10:0] pac_x,
    output logic signed [10:0] pac_y,
    output logic [1:0]         direction,
    output logic [1:0]         frame_sel,
    output logic               upd
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic signed [10:0] STEP    = 11'(SCALE);
    localparam logic signed [10:0] X_MIN   = 11'(-(SPRITE_W * SCALE));
    localparam logic signed [10:0] Y_MIN   = 11'(-(SPRITE_W * SCALE));
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H);
    localparam logic signed [10:0] RESET_X = 11'((SCREEN_W - SPRITE_W * SCALE) / 2);
    localparam logic signed [10:0] RESET_Y = 11'((SCREEN_H - SPRITE_W * SCALE) / 2);
    localparam logic [CNT_W-1:0]   ANIM_LAST = CNT_W'(ANIM_DIV - 1);

    logic               tick;
    logic               rise_any;
    dir_t               rise_dir;
    logic               pending_valid;
    dir_t               pending_dir;
    dir_t               dir_q;
    dir_t               new_dir;
    logic signed [10:0] next_x;
    logic signed [10:0] next_y;
    logic [CNT_W-1:0]   anim_cnt;

    assign tick      = ce & frame_tick & ~pause;
    assign direction = dir_q;

    turn_buffer u_turn_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .clear         (tick),
        .btn           (btn),
        .rise_any      (rise_any),
        .rise_dir      (rise_dir),
        .pending_valid (pending_valid),
        .pending_dir   (pending_dir)
    );

    // Heading for this tick: a same-cycle press beats the buffered one.
    // Then one step along it, wrapping fully off-screen to the far edge.
    always_comb begin
        if (rise_any)           new_dir = rise_dir;
        else if (pending_valid) new_dir = pending_dir;
        else                    new_dir = dir_q;

        next_x = pac_x;
        next_y = pac_y;
        unique case (new_dir)
            DIR_RIGHT: next_x = (pac_x >= X_MAX) ? X_MIN : pac_x + STEP;
            DIR_LEFT:  next_x = (pac_x <= X_MIN) ? X_MAX : pac_x - STEP;
            DIR_DOWN:  next_y = (pac_y >= Y_MAX) ? Y_MIN : pac_y + STEP;
            DIR_UP:    next_y = (pac_y <= Y_MIN) ? Y_MAX : pac_y - STEP;
        endcase
    end

    // Registered outputs: commit motion and animation on tick, pulse upd after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pac_x     <= RESET_X;
            pac_y     <= RESET_Y;
            dir_q     <= DIR_RIGHT;
            frame_sel <= 2'd0;
            anim_cnt  <= '0;
            upd       <= 1'b0;
        end else begin
            upd <= tick;
            if (tick) begin
                dir_q <= new_dir;
                pac_x <= next_x;
                pac_y <= next_y;
                if (anim_cnt == ANIM_LAST) begin
                    anim_cnt  <= '0;
                    frame_sel <= frame_sel + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pac_motion.sv
// Directed bench for pac_motion: walk, wrap, turn buffering, animation,
// pause and asynchronous reset, with hand-computed expected values.
module tb_pac_motion;

    logic               clk;
    logic               rst_n;
    logic               ce;
    logic               frame_tick;
    logic [3:0]         btn;
    logic               pause;
    logic signed [10:0] pac_x;
    logic signed [10:0] pac_y;
    logic [1:0]         direction;
    logic [1:0]         frame_sel;
    logic               upd;

    int   n_assert;
    int   n_fail;
    logic upd_seen;
    logic upd_after;
    logic signed [10:0] exp_q[$];

    pac_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .frame_tick (frame_tick),
        .btn        (btn),
        .pause      (pause),
        .pac_x      (pac_x),
        .pac_y      (pac_y),
        .direction  (direction),
        .frame_sel  (frame_sel),
        .upd        (upd)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ce cycle (optionally a frame tick) followed by three idle clocks.
    // upd_seen is sampled just after the ce edge, upd_after three clocks later.
    task automatic ce_pulse(input logic ft);
        @(negedge clk);
        ce         = 1'b1;
        frame_tick = ft;
        @(posedge clk);
        #1;
        ce         = 1'b0;
        frame_tick = 1'b0;
        upd_seen   = upd;
        repeat (3) @(posedge clk);
        #1;
        upd_after = upd;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) ce_pulse(1'b1);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        ce         = 1'b0;
        frame_tick = 1'b0;
        btn        = 4'b0000;
        pause      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", pac_x, 304);
        check("reset_y", pac_y, 224);
        check("reset_dir", direction, 1);
        check("reset_frame", frame_sel, 0);
        check("reset_upd", upd, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three ticks with no buttons: straight right by 2 each.
        exp_q.push_back(11'sd306);
        exp_q.push_back(11'sd308);
        exp_q.push_back(11'sd310);
        for (int i = 0; i < 3; i++) begin
            ce_pulse(1'b1);
            check("walk_x", pac_x, exp_q.pop_front());
            check("walk_y", pac_y, 224);
            check("walk_dir", direction, 1);
            check("walk_upd_pulse", upd_seen, 1);
            check("walk_upd_low", upd_after, 0);
        end
        ce_pulse(1'b0);
        check("no_tick_upd", upd_seen, 0);

        // Animation pacing: advance every 5 ticks.
        ce_pulse(1'b1);                         // tick 4
        check("anim_t4", frame_sel, 0);
        ce_pulse(1'b1);                         // tick 5
        check("anim_t5", frame_sel, 1);
        check("anim_t5_x", pac_x, 314);
        tick_n(14);                             // tick 19
        check("anim_t19", frame_sel, 3);
        ce_pulse(1'b1);                         // tick 20
        check("anim_t20", frame_sel, 0);
        check("anim_t20_x", pac_x, 344);

        // Right wrap.
        tick_n(148);                            // tick 168
        check("wrap_640", pac_x, 640);
        ce_pulse(1'b1);                         // tick 169
        check("wrap_min", pac_x, -32);
        ce_pulse(1'b1);                         // tick 170
        check("wrap_after", pac_x, -30);
        check("wrap_y", pac_y, 224);
        check("wrap_frame", frame_sel, 2);

        // UP held for two ce cycles, released, then applied on next tick.
        btn = 4'b0001;
        ce_pulse(1'b0);
        ce_pulse(1'b0);
        btn = 4'b0000;
        ce_pulse(1'b0);
        check("buffer_no_move", pac_y, 224);
        ce_pulse(1'b1);                         // tick 171
        check("up_dir", direction, 0);
        check("up_y", pac_y, 222);
        check("up_x", pac_x, -30);

        // Held UP must not re-request after RIGHT is taken.
        btn = 4'b0001;
        ce_pulse(1'b0);
        btn = 4'b0101;
        ce_pulse(1'b0);
        ce_pulse(1'b1);                         // tick 172
        check("hold_right_dir", direction, 1);
        check("hold_right_x", pac_x, -28);
        ce_pulse(1'b1);                         // tick 173
        check("hold_no_rereq", direction, 1);
        check("hold_x", pac_x, -26);
        check("hold_y", pac_y, 222);
        btn = 4'b0000;
        ce_pulse(1'b0);

        // LEFT and DOWN together: LEFT wins on priority.
        btn = 4'b1010;
        ce_pulse(1'b0);
        btn = 4'b0000;
        ce_pulse(1'b1);                         // tick 174
        check("prio_left", direction, 2);
        check("prio_left_x", pac_x, -28);

        // DOWN then UP before the tick: last press wins.
        btn = 4'b1000;
        ce_pulse(1'b0);
        btn = 4'b0000;
        ce_pulse(1'b0);
        btn = 4'b0001;
        ce_pulse(1'b0);
        btn = 4'b0000;
        ce_pulse(1'b1);                         // tick 175
        check("last_wins_dir", direction, 0);
        check("last_wins_y", pac_y, 220);
        check("last_wins_x", pac_x, -28);

        // RIGHT rising in the tick cycle itself is applied at once.
        btn = 4'b0100;
        ce_pulse(1'b1);                         // tick 176
        check("bypass_dir", direction, 1);
        check("bypass_x", pac_x, -26);
        btn = 4'b0000;
        ce_pulse(1'b1);                         // tick 177
        check("bypass_cleared", direction, 1);
        check("bypass_next_x", pac_x, -24);
        check("pre_pause_frame", frame_sel, 3);

        // Pause: ticks ignored, a press still buffers.
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn = (i == 4) ? 4'b1000 : 4'b0000;
            ce_pulse(1'b1);
            check("pause_upd", upd_seen, 0);
        end
        check("pause_x", pac_x, -24);
        check("pause_y", pac_y, 220);
        check("pause_frame", frame_sel, 3);
        check("pause_dir", direction, 1);
        pause = 1'b0;
        btn   = 4'b0000;
        ce_pulse(1'b1);                         // tick 178
        check("unpause_dir", direction, 3);
        check("unpause_y", pac_y, 222);
        check("unpause_upd", upd_seen, 1);
        tick_n(2);                              // tick 180
        check("unpause_frame", frame_sel, 0);
        check("unpause_y2", pac_y, 226);

        // Asynchronous reset mid-frame with a pending UP request.
        btn = 4'b0001;
        ce_pulse(1'b0);
        btn = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_x", pac_x, 304);
        check("areset_y", pac_y, 224);
        check("areset_dir", direction, 1);
        check("areset_frame", frame_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ce_pulse(1'b1);
        check("post_reset_dir", direction, 1);
        check("post_reset_x", pac_x, 306);
        check("post_reset_y", pac_y, 224);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
